// File: rtl/writeback_stage_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : writeback_stage_if
// Purpose  : Memory-stage handshake, load return and register-file write bus
//            of the writeback stage.
// Revision : 1.0
// ============================================================================
interface writeback_stage_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) ();
  logic                      i_Valid;
  logic                      o_Ready;
  logic [REG_ADDR_WIDTH-1:0] i_Rd_Addr;
  logic                      i_Rd_Write;
  logic [1:0]                i_Wb_Src;
  logic [XLEN-1:0]           i_Alu_Result;
  logic [XLEN-1:0]           i_Pc_Plus_4;
  logic [XLEN-1:0]           i_Csr_Data;
  logic [1:0]                i_Load_Size;
  logic                      i_Load_Unsigned;
  logic [XLEN-1:0]           i_Load_Data;
  logic                      i_Load_Data_Valid;
  logic                      o_Write_Enable;
  logic [REG_ADDR_WIDTH-1:0] o_Write_Addr;
  logic [XLEN-1:0]           o_Write_Data;
  logic                      o_Fwd_Valid;
  logic                      o_Misaligned;
  logic [63:0]               o_Instret;

  // Upstream pipeline / data memory / register file side
  modport master (
    output i_Valid, i_Rd_Addr, i_Rd_Write, i_Wb_Src, i_Alu_Result,
           i_Pc_Plus_4, i_Csr_Data, i_Load_Size, i_Load_Unsigned,
           i_Load_Data, i_Load_Data_Valid,
    input  o_Ready, o_Write_Enable, o_Write_Addr, o_Write_Data,
           o_Fwd_Valid, o_Misaligned, o_Instret
  );

  // Writeback stage side
  modport slave (
    input  i_Valid, i_Rd_Addr, i_Rd_Write, i_Wb_Src, i_Alu_Result,
           i_Pc_Plus_4, i_Csr_Data, i_Load_Size, i_Load_Unsigned,
           i_Load_Data, i_Load_Data_Valid,
    output o_Ready, o_Write_Enable, o_Write_Addr, o_Write_Data,
           o_Fwd_Valid, o_Misaligned, o_Instret
  );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage; selects the retiring result (ALU, load,
//            PC+4, CSR), drives the register-file write port and forwarding.
// Config   : WB_INSTRET_EN enables the 64-bit retired-instruction counter.
// Revision : 1.0
// ============================================================================
module writeback_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic             i_Clock,
  input  logic             i_Reset_N,
  writeback_stage_if.slave wb
);

  localparam logic [1:0] SRC_ALU   = 2'b00;
  localparam logic [1:0] SRC_LOAD  = 2'b01;
  localparam logic [1:0] SRC_PC4   = 2'b10;
  localparam logic [1:0] SRC_CSR   = 2'b11;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_HOLD      = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } state_e;

  state_e                    state_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      rd_write_q;
  logic [1:0]                wb_src_q;
  logic [XLEN-1:0]           alu_q;
  logic [XLEN-1:0]           pc4_q;
  logic [XLEN-1:0]           csr_q;
  logic [1:0]                load_size_q;
  logic                      load_unsigned_q;

  logic                      commit;
  logic                      ready;
  logic                      transfer;
  logic [1:0]                offset;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [XLEN-1:0]           load_value;
  logic [XLEN-1:0]           result;
  logic                      misaligned;

  // A stage slot frees in the same cycle it commits, giving 1 instr/cycle.
  assign commit   = (state_q == ST_HOLD) |
                    ((state_q == ST_WAIT_LOAD) & wb.i_Load_Data_Valid);
  assign ready    = (state_q == ST_EMPTY) | commit;
  assign transfer = wb.i_Valid & ready;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q         <= ST_EMPTY;
      rd_addr_q       <= '0;
      rd_write_q      <= 1'b0;
      wb_src_q        <= SRC_ALU;
      alu_q           <= '0;
      pc4_q           <= '0;
      csr_q           <= '0;
      load_size_q     <= SIZE_BYTE;
      load_unsigned_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY, ST_HOLD, ST_WAIT_LOAD: begin
          if (transfer) begin
            state_q <= (wb.i_Wb_Src == SRC_LOAD) ? ST_WAIT_LOAD : ST_HOLD;
          end else if (commit) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase

      if (transfer) begin
        rd_addr_q       <= wb.i_Rd_Addr;
        rd_write_q      <= wb.i_Rd_Write;
        wb_src_q        <= wb.i_Wb_Src;
        alu_q           <= wb.i_Alu_Result;
        pc4_q           <= wb.i_Pc_Plus_4;
        csr_q           <= wb.i_Csr_Data;
        load_size_q     <= wb.i_Load_Size;
        load_unsigned_q <= wb.i_Load_Unsigned;
      end
    end
  end

  assign offset = alu_q[1:0];

  // Load data arrives word-aligned; extract the addressed lane, then extend.
  always_comb begin
    ld_byte = wb.i_Load_Data[7:0];
    unique case (offset)
      2'd0: ld_byte = wb.i_Load_Data[7:0];
      2'd1: ld_byte = wb.i_Load_Data[15:8];
      2'd2: ld_byte = wb.i_Load_Data[23:16];
      2'd3: ld_byte = wb.i_Load_Data[31:24];
      default: ld_byte = wb.i_Load_Data[7:0];
    endcase
    ld_half = offset[1] ? wb.i_Load_Data[31:16] : wb.i_Load_Data[15:0];
  end

  always_comb begin
    load_value = wb.i_Load_Data;
    unique case (load_size_q)
      SIZE_BYTE: load_value = {{(XLEN-8){~load_unsigned_q & ld_byte[7]}}, ld_byte};
      SIZE_HALF: load_value = {{(XLEN-16){~load_unsigned_q & ld_half[15]}}, ld_half};
      default:   load_value = wb.i_Load_Data;
    endcase
  end

  always_comb begin
    result = alu_q;
    unique case (wb_src_q)
      SRC_ALU:  result = alu_q;
      SRC_LOAD: result = load_value;
      SRC_PC4:  result = pc4_q;
      SRC_CSR:  result = csr_q;
      default:  result = alu_q;
    endcase
  end

  // Size 11 is treated as a word access, so any nonzero offset faults.
  assign misaligned = (wb_src_q == SRC_LOAD) &
                      (((load_size_q == SIZE_HALF) & offset[0]) |
                       (load_size_q[1] & (offset != 2'b00)));

  assign wb.o_Ready        = ready;
  assign wb.o_Write_Enable = commit & rd_write_q & (rd_addr_q != '0) & ~misaligned;
  assign wb.o_Fwd_Valid    = wb.o_Write_Enable;
  assign wb.o_Write_Addr   = rd_addr_q;
  assign wb.o_Write_Data   = result;
  assign wb.o_Misaligned   = commit & misaligned;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      instret_q <= 64'd0;
    end else if (commit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign wb.o_Instret = instret_q;
`else
  assign wb.o_Instret = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Vector table plus hand sequences for writeback_stage, checked
//            against an in-order expected-write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_writeback_stage;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int NVEC = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(RAW)) wbi ();

  writeback_stage #(.XLEN(XLEN), .REG_ADDR_WIDTH(RAW)) dut (
    .i_Clock   (clk),
    .i_Reset_N (rst_n),
    .wb        (wbi)
  );

  typedef struct {
    logic [RAW-1:0] rd;
    logic           rdw;
    logic [1:0]     src;
    logic [31:0]    opnd;
    logic [31:0]    aux;
    logic [1:0]     size;
    logic           uns;
    logic [31:0]    ld;
    int             delay;
    logic           exp_we;
    logic           exp_mis;
    logic [31:0]    exp_data;
  } vec_t;

  typedef struct {
    logic           we;
    logic           mis;
    logic [RAW-1:0] addr;
    logic [31:0]    data;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  vec_t   vecs[NVEC];
  int     n_checks = 0;
  int     n_pass   = 0;
  longint exp_ret  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
    return exp_ret;
`else
    return 64'd0;
`endif
  endfunction

  function automatic vec_t mk(input logic [RAW-1:0] rd, input logic rdw, input logic [1:0] src,
                              input logic [31:0] opnd, input logic [31:0] aux,
                              input logic [1:0] size, input logic uns, input logic [31:0] ld,
                              input int delay, input logic we, input logic mis,
                              input logic [31:0] data);
    vec_t v;
    v.rd = rd; v.rdw = rdw; v.src = src; v.opnd = opnd; v.aux = aux; v.size = size;
    v.uns = uns; v.ld = ld; v.delay = delay; v.exp_we = we; v.exp_mis = mis;
    v.exp_data = data;
    return v;
  endfunction

  // Every visible commit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wbi.o_Write_Enable || wbi.o_Misaligned || wbi.o_Fwd_Valid) begin
      if (sb.size() == 0) begin
        check("unexpected_commit",
              {61'd0, wbi.o_Write_Enable, wbi.o_Misaligned, wbi.o_Fwd_Valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("write_enable", wbi.o_Write_Enable, mon_e.we);
        check("fwd_valid",    wbi.o_Fwd_Valid,    mon_e.we);
        check("misaligned",   wbi.o_Misaligned,   mon_e.mis);
        if (mon_e.we) begin
          check("write_addr", wbi.o_Write_Addr, mon_e.addr);
          check("write_data", wbi.o_Write_Data, mon_e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    wbi.i_Valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    wbi.i_Valid           = 1'b1;
    wbi.i_Rd_Addr         = v.rd;
    wbi.i_Rd_Write        = v.rdw;
    wbi.i_Wb_Src          = v.src;
    wbi.i_Alu_Result      = v.opnd;
    wbi.i_Pc_Plus_4       = v.aux;
    wbi.i_Csr_Data        = v.aux ^ 32'h5A5A_5A5A;
    wbi.i_Load_Size       = v.size;
    wbi.i_Load_Unsigned   = v.uns;
    wbi.i_Load_Data       = ~v.ld;
    wbi.i_Load_Data_Valid = 1'b0;
    @(negedge clk);
    while (!wbi.o_Ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("ready_on_issue", waited, 0);
    @(posedge clk);
    if (v.exp_we || v.exp_mis) sb.push_back('{v.exp_we, v.exp_mis, v.rd, v.exp_data});
    #1 wbi.i_Valid = 1'b0;
    if (v.src == 2'b01) begin
      for (int i = 0; i < v.delay; i++) begin
        @(negedge clk);
        check("ready_during_stall", wbi.o_Ready, 1'b0);
        @(posedge clk);
        #1;
      end
      wbi.i_Load_Data       = v.ld;
      wbi.i_Load_Data_Valid = 1'b1;
      @(posedge clk);
      #1 wbi.i_Load_Data_Valid = 1'b0;
    end
    exp_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    wbi.i_Valid = 1'b0; wbi.i_Rd_Addr = '0; wbi.i_Rd_Write = 1'b0; wbi.i_Wb_Src = 2'b00;
    wbi.i_Alu_Result = '0; wbi.i_Pc_Plus_4 = '0; wbi.i_Csr_Data = '0;
    wbi.i_Load_Size = 2'b00; wbi.i_Load_Unsigned = 1'b0; wbi.i_Load_Data = '0;
    wbi.i_Load_Data_Valid = 1'b0;

    //          rd  rdw src opnd          aux       sz  u  ld            dly we mis data
    vecs[0]  = mk(5,  1, 0, 32'h1234,     32'h0,    0, 0, 32'h0,        0, 1, 0, 32'h1234);
    vecs[1]  = mk(1,  1, 0, 32'hA,        32'h3,    0, 0, 32'h0,        0, 1, 0, 32'hA);
    vecs[2]  = mk(2,  1, 0, 32'hB,        32'h3,    0, 0, 32'h0,        0, 1, 0, 32'hB);
    vecs[3]  = mk(3,  1, 0, 32'hC,        32'h3,    0, 0, 32'h0,        0, 1, 0, 32'hC);
    vecs[4]  = mk(6,  1, 1, 32'h1003,     32'h0,    0, 0, 32'h80FF_0000, 2, 1, 0, 32'hFFFF_FF80);
    vecs[5]  = mk(7,  1, 1, 32'h1003,     32'h0,    0, 1, 32'h80FF_0000, 0, 1, 0, 32'h0000_0080);
    vecs[6]  = mk(8,  1, 1, 32'h2001,     32'h0,    1, 0, 32'h1234_5678, 1, 0, 1, 32'h0);
    vecs[7]  = mk(0,  1, 2, 32'h99,       32'h100,  0, 0, 32'h0,        0, 0, 0, 32'h0);
    vecs[8]  = mk(9,  1, 3, 32'h99,       32'h0,    0, 0, 32'h0,        0, 1, 0, 32'h5A5A_5A5A);
    vecs[9]  = mk(10, 1, 1, 32'h2002,     32'h0,    1, 0, 32'h8001_7FFF, 0, 1, 0, 32'hFFFF_8001);
    vecs[10] = mk(11, 1, 1, 32'h2000,     32'h0,    1, 1, 32'h8001_7FFF, 1, 1, 0, 32'h0000_7FFF);
    vecs[11] = mk(12, 1, 1, 32'h3000,     32'h0,    2, 0, 32'hCAFE_F00D, 0, 1, 0, 32'hCAFE_F00D);
    vecs[12] = mk(13, 1, 1, 32'h3002,     32'h0,    3, 0, 32'h1111_2222, 0, 0, 1, 32'h0);
    vecs[13] = mk(14, 1, 1, 32'h4001,     32'h0,    0, 0, 32'h0000_7F00, 0, 1, 0, 32'h0000_007F);
    vecs[14] = mk(15, 0, 0, 32'h55,       32'h0,    0, 0, 32'h0,        0, 0, 0, 32'h0);
    vecs[15] = mk(1,  1, 2, 32'h77,       32'h200,  0, 0, 32'h0,        0, 1, 0, 32'h200);
    vecs[16] = mk(31, 1, 0, 32'hFFFF_FFFF, 32'h0,   0, 0, 32'h0,        0, 1, 0, 32'hFFFF_FFFF);
    vecs[17] = mk(20, 1, 1, 32'h5002,     32'h0,    0, 0, 32'h0080_0000, 0, 1, 0, 32'hFFFF_FF80);
    vecs[18] = mk(0,  1, 1, 32'h6001,     32'h0,    1, 0, 32'h0,        0, 0, 1, 32'h0);
    vecs[19] = mk(21, 1, 1, 32'h7000,     32'h0,    3, 0, 32'h89AB_CDEF, 0, 1, 0, 32'h89AB_CDEF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready",      wbi.o_Ready,        1'b1);
    check("reset_we",         wbi.o_Write_Enable, 1'b0);
    check("reset_fwd",        wbi.o_Fwd_Valid,    1'b0);
    check("reset_misaligned", wbi.o_Misaligned,   1'b0);
    check("reset_addr",       wbi.o_Write_Addr,   '0);
    check("reset_data",       wbi.o_Write_Data,   '0);
    check("reset_instret",    wbi.o_Instret,      64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(vecs[0]);
    idle(2);
    check("instret_first_alu", wbi.o_Instret, exp_instret());

    for (int i = 1; i < NVEC; i++) send(vecs[i]);
    idle(2);
    check("instret_after_table", wbi.o_Instret, exp_instret());
    check("scoreboard_drained", sb.size(), 0);

    // Load-data strobe with no load outstanding must be ignored.
    wbi.i_Load_Data       = 32'hFFFF_FFFF;
    wbi.i_Load_Data_Valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_ldv_ready", wbi.o_Ready,        1'b1);
      check("stray_ldv_we",    wbi.o_Write_Enable, 1'b0);
    end
    @(posedge clk);
    #1 wbi.i_Load_Data_Valid = 1'b0;
    check("stray_ldv_instret", wbi.o_Instret, exp_instret());

    // Reset while a load waits for data: the load is discarded.
    wbi.i_Valid = 1'b1; wbi.i_Rd_Addr = 5'd3; wbi.i_Rd_Write = 1'b1; wbi.i_Wb_Src = 2'b01;
    wbi.i_Alu_Result = 32'h100; wbi.i_Load_Size = 2'b10; wbi.i_Load_Unsigned = 1'b0;
    @(negedge clk);
    check("rst_seq_ready_issue", wbi.o_Ready, 1'b1);
    @(posedge clk);
    #1 wbi.i_Valid = 1'b0;
    @(negedge clk);
    check("rst_seq_wait_ready", wbi.o_Ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_seq_ready", wbi.o_Ready,        1'b1);
    check("rst_seq_we",    wbi.o_Write_Enable, 1'b0);
    check("rst_seq_fwd",   wbi.o_Fwd_Valid,    1'b0);
    check("rst_seq_mis",   wbi.o_Misaligned,   1'b0);
    check("rst_seq_data",  wbi.o_Write_Data,   '0);
    check("rst_seq_instret", wbi.o_Instret,    64'd0);
    exp_ret = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wbi.i_Load_Data       = 32'h1234_5678;
    wbi.i_Load_Data_Valid = 1'b1;
    @(negedge clk);
    check("rst_seq_post_we",    wbi.o_Write_Enable, 1'b0);
    check("rst_seq_post_ready", wbi.o_Ready,        1'b1);
    @(posedge clk);
    #1 wbi.i_Load_Data_Valid = 1'b0;
    check("rst_seq_post_instret", wbi.o_Instret, exp_instret());

    send(mk(4, 1, 0, 32'hBEEF, 32'h0, 0, 0, 32'h0, 0, 1, 0, 32'hBEEF));
    idle(2);
    check("post_reset_instret", wbi.o_Instret, exp_instret());
    check("final_scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
